// File: rtl/gcbp_subimage_wr_router_if.sv
`default_nettype none
// ============================================================================
//  Module      : gcbp_subimage_wr_router_if
//  Description : Pixel-stream input and subimage BRAM write bundle for the
//                GCBP subimage write router.
//  Revision    : 1.0 - initial release
// ============================================================================
interface gcbp_subimage_wr_router_if #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 15,
  parameter int NUM_SUB = 16
);
  logic               pix_valid;
  logic               pix_sof;
  logic [DATA_W-1:0]  pix_data;
  logic [NUM_SUB-1:0] sub_mask;
  logic [NUM_SUB-1:0] bram_we;
  logic [ADDR_W-1:0]  bram_addr;
  logic [DATA_W-1:0]  bram_din;
  logic               frame_busy;
  logic               frame_done;
  logic               sync_err;

  // Video source side: drives pixels and masks, observes the write port.
  modport master (
    output pix_valid, pix_sof, pix_data, sub_mask,
    input  bram_we, bram_addr, bram_din, frame_busy, frame_done, sync_err
  );

  // Router side.
  modport slave (
    input  pix_valid, pix_sof, pix_data, sub_mask,
    output bram_we, bram_addr, bram_din, frame_busy, frame_done, sync_err
  );
endinterface
`default_nettype wire

// File: rtl/gcbp_subimage_wr_router.sv
`default_nettype none
// ============================================================================
//  Module      : gcbp_subimage_wr_router
//  Description : Steers a raster pixel stream into a GRID_V x GRID_H bank of
//                subimage BRAMs with registered one-hot write enables and
//                subimage-local addresses.
//  Revision    : 1.0 - initial release
// ============================================================================
module gcbp_subimage_wr_router #(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int GRID_H = 4,
  parameter int GRID_V = 4,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 15
) (
  input  wire logic                   clk,
  input  wire logic                   rst,
  gcbp_subimage_wr_router_if.slave    bus
);

  localparam int c_SUB_W   = IMG_W / GRID_H;
  localparam int c_SUB_H   = IMG_H / GRID_V;
  localparam int c_NUM_SUB = GRID_H * GRID_V;

  // Counter widths; a one-entry range still gets a 1-bit counter.
  localparam int c_HORI_W = (GRID_H    > 1) ? $clog2(GRID_H)    : 1;
  localparam int c_VERT_W = (GRID_V    > 1) ? $clog2(GRID_V)    : 1;
  localparam int c_SCOL_W = (c_SUB_W   > 1) ? $clog2(c_SUB_W)   : 1;
  localparam int c_SROW_W = (c_SUB_H   > 1) ? $clog2(c_SUB_H)   : 1;
  localparam int c_IDX_W  = (c_NUM_SUB > 1) ? $clog2(c_NUM_SUB) : 1;

  localparam logic [c_HORI_W-1:0] c_HORI_MAX = c_HORI_W'(GRID_H - 1);
  localparam logic [c_VERT_W-1:0] c_VERT_MAX = c_VERT_W'(GRID_V - 1);
  localparam logic [c_SCOL_W-1:0] c_SCOL_MAX = c_SCOL_W'(c_SUB_W - 1);
  localparam logic [c_SROW_W-1:0] c_SROW_MAX = c_SROW_W'(c_SUB_H - 1);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  state_t                r_state;
  logic [c_HORI_W-1:0]   r_hori;
  logic [c_VERT_W-1:0]   r_vert;
  logic [c_SCOL_W-1:0]   r_sub_col;
  logic [c_SROW_W-1:0]   r_sub_row;

  logic                  w_accept;
  logic                  w_restart;
  logic                  w_last;
  logic                  w_col_end;
  logic                  w_row_end;
  logic [c_HORI_W-1:0]   w_hori;
  logic [c_VERT_W-1:0]   w_vert;
  logic [c_SCOL_W-1:0]   w_sub_col;
  logic [c_SROW_W-1:0]   w_sub_row;
  logic [c_HORI_W-1:0]   w_nxt_hori;
  logic [c_VERT_W-1:0]   w_nxt_vert;
  logic [c_SCOL_W-1:0]   w_nxt_sub_col;
  logic [c_SROW_W-1:0]   w_nxt_sub_row;
  logic [c_IDX_W-1:0]    w_idx;
  logic [31:0]           w_addr_full;
  logic [c_NUM_SUB-1:0]  w_onehot;

  // A sof pixel always lands at (0,0); otherwise it takes the running position.
  always_comb begin
    w_accept  = bus.pix_valid && (bus.pix_sof || (r_state == S_ACTIVE));
    w_restart = bus.pix_valid && bus.pix_sof && (r_state == S_ACTIVE);
    w_hori    = bus.pix_sof ? '0 : r_hori;
    w_vert    = bus.pix_sof ? '0 : r_vert;
    w_sub_col = bus.pix_sof ? '0 : r_sub_col;
    w_sub_row = bus.pix_sof ? '0 : r_sub_row;
    w_col_end = (w_sub_col == c_SCOL_MAX) && (w_hori == c_HORI_MAX);
    w_row_end = (w_sub_row == c_SROW_MAX) && (w_vert == c_VERT_MAX);
    // A sof on the final position is a restart, never a completion.
    w_last    = w_col_end && w_row_end && !w_restart;
    w_idx       = c_IDX_W'(32'(w_vert) * GRID_H + 32'(w_hori));
    w_addr_full = 32'(w_sub_row) * c_SUB_W + 32'(w_sub_col);
    w_onehot    = c_NUM_SUB'(1) << w_idx;
  end

  // Column pair wraps first; end of line advances the row pair.
  always_comb begin
    w_nxt_sub_col = w_sub_col + c_SCOL_W'(1);
    w_nxt_hori    = w_hori;
    w_nxt_sub_row = w_sub_row;
    w_nxt_vert    = w_vert;
    if (w_sub_col == c_SCOL_MAX) begin
      w_nxt_sub_col = '0;
      if (w_hori == c_HORI_MAX) begin
        w_nxt_hori = '0;
        if (w_sub_row == c_SROW_MAX) begin
          w_nxt_sub_row = '0;
          w_nxt_vert    = (w_vert == c_VERT_MAX) ? '0 : w_vert + c_VERT_W'(1);
        end else begin
          w_nxt_sub_row = w_sub_row + c_SROW_W'(1);
        end
      end else begin
        w_nxt_hori = w_hori + c_HORI_W'(1);
      end
    end
    if (w_last) begin
      w_nxt_sub_col = '0;
      w_nxt_hori    = '0;
      w_nxt_sub_row = '0;
      w_nxt_vert    = '0;
    end
  end

  // Frame FSM, position counters and registered write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_hori         <= '0;
      r_vert         <= '0;
      r_sub_col      <= '0;
      r_sub_row      <= '0;
      bus.bram_we    <= '0;
      bus.bram_addr  <= '0;
      bus.bram_din   <= '0;
      bus.frame_busy <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.sync_err   <= 1'b0;
    end else begin
      bus.frame_busy <= (r_state == S_ACTIVE);
      bus.frame_done <= w_accept && w_last;
      bus.sync_err   <= w_restart;
      if (w_accept) begin
        r_state       <= w_last ? S_IDLE : S_ACTIVE;
        r_hori        <= w_nxt_hori;
        r_vert        <= w_nxt_vert;
        r_sub_col     <= w_nxt_sub_col;
        r_sub_row     <= w_nxt_sub_row;
        bus.bram_addr <= w_addr_full[ADDR_W-1:0];
        bus.bram_din  <= bus.pix_data;
        bus.bram_we   <= bus.sub_mask[w_idx] ? '0 : w_onehot;
      end else begin
        bus.bram_we   <= '0;
      end
    end
  end

endmodule
`default_nettype wire
